// File: rtl/outlier_fifo_arbiter.sv
// Round-robin arbiter that serialises outlier indices from parallel cores into one FWFT FIFO.
// Optional transfer counter output outlier_total is enabled with `define OUTLIER_FIFO_STATS_EN.
module outlier_fifo_arbiter #(
   parameter int CORE_NUMBER = 4,
   parameter int N           = 16,
   parameter int FIFO_DEPTH  = 64,
   parameter int AW          = $clog2(FIFO_DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [CORE_NUMBER-1:0]     core_valid,
   input  logic [N*CORE_NUMBER-1:0]   core_index,
   output logic [CORE_NUMBER-1:0]     core_ready,
   input  logic                       read_fifo,
   output logic [N-1:0]               outlier_pos_fifo,
   output logic                       empty,
   output logic                       full,
   output logic [AW:0]                count
`ifdef OUTLIER_FIFO_STATS_EN
   ,output logic [31:0]               outlier_total
`endif
);

   localparam int RRW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;

   logic [N-1:0]     mem [FIFO_DEPTH];
   logic [N-1:0]     idx_arr [CORE_NUMBER];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [RRW-1:0]   rr_ptr_q, rr_ptr_d;

   logic [CORE_NUMBER-1:0] grant_vec;
   logic [RRW-1:0]   grant_idx;
   logic             grant_any;
   logic [N-1:0]     push_data;
   logic             push;
   logic             pop;

   genvar gi;
   generate
      for (gi = 0; gi < CORE_NUMBER; gi++) begin : g_unpack
         assign idx_arr[gi] = core_index[N*gi +: N];
      end
   endgenerate

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign count = count_q;

   // Scan from rr_ptr with wrap; reset also masks the grant so core_ready is 0 while it is held.
   always_comb begin
      int c;
      grant_vec = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      push_data = '0;
      c         = 0;
      if (!full && !flush && !reset) begin
         for (int k = 0; k < CORE_NUMBER; k++) begin
            c = (int'(rr_ptr_q) + k) % CORE_NUMBER;
            if (!grant_any && core_valid[c]) begin
               grant_any    = 1'b1;
               grant_vec[c] = 1'b1;
               grant_idx    = RRW'(c);
               push_data    = idx_arr[c];
            end
         end
      end
   end

   assign core_ready = grant_vec;
   assign push       = grant_any;
   assign pop        = read_fifo && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         rr_ptr_d = RRW'((int'(grant_idx) + 1) % CORE_NUMBER);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         rr_ptr_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Storage is deliberately not reset; the head is read asynchronously for first-word-fall-through.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   assign outlier_pos_fifo = empty ? '0 : mem[rd_ptr_q];

`ifdef OUTLIER_FIFO_STATS_EN
   logic [31:0] total_q, total_d;

   always_comb begin
      total_d = total_q;
      if (flush) begin
         total_d = '0;
      end else if (push && (total_q != 32'hFFFF_FFFF)) begin
         total_d = total_q + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign outlier_total = total_q;
`endif

endmodule

// File: tb/tb_outlier_fifo_arbiter.sv
// Self-checking bench for outlier_fifo_arbiter: vector table, corner sequences and a randomized
// run against a queue-based reference model.
module tb_outlier_fifo_arbiter;

   localparam int C     = 4;
   localparam int N     = 16;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic [C-1:0]  core_valid;
   logic [N*C-1:0] core_index;
   logic [C-1:0]  core_ready;
   logic          read_fifo;
   logic [N-1:0]  outlier_pos_fifo;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
`ifdef OUTLIER_FIFO_STATS_EN
   logic [31:0]   outlier_total;
   longint        m_total;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: a queue of indices and the round-robin start position
   int unsigned mq[$];
   int          m_rr;

   always #5 clock = ~clock;

   outlier_fifo_arbiter #(.CORE_NUMBER(C), .N(N), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .core_valid(core_valid), .core_index(core_index), .core_ready(core_ready),
      .read_fifo(read_fifo), .outlier_pos_fifo(outlier_pos_fifo),
      .empty(empty), .full(full), .count(count)
`ifdef OUTLIER_FIFO_STATS_EN
      , .outlier_total(outlier_total)
`endif
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [C-1:0] model_grant();
      if (flush || reset || mq.size() == DEPTH) return '0;
      for (int k = 0; k < C; k++) begin
         int c;
         c = (m_rr + k) % C;
         if (core_valid[c]) return C'(1) << c;
      end
      return '0;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_rr = 0;
`ifdef OUTLIER_FIFO_STATS_EN
      m_total = 0;
`endif
   endtask

   // One clock with model tracking; inputs must already be driven.
   task automatic do_cycle(input string tag);
      logic [C-1:0] g;
      #1;
      g = model_grant();
      check({tag, " ready"}, core_ready, g);
      @(posedge clock);
      if (flush) begin
         model_clear();
      end else begin
         if (read_fifo && mq.size() > 0) void'(mq.pop_front());
         for (int c = 0; c < C; c++) begin
            if (g[c]) begin
               mq.push_back(int'(core_index[N*c +: N]));
               m_rr = (c + 1) % C;
`ifdef OUTLIER_FIFO_STATS_EN
               m_total++;
`endif
            end
         end
      end
      #1;
      check({tag, " count"}, count, mq.size());
      check({tag, " empty"}, empty, mq.size() == 0);
      check({tag, " full"}, full, mq.size() == DEPTH);
      check({tag, " head"}, outlier_pos_fifo, (mq.size() > 0) ? mq[0] : 0);
`ifdef OUTLIER_FIFO_STATS_EN
      check({tag, " total"}, outlier_total, m_total);
`endif
   endtask

   task automatic set_in(input logic [C-1:0] v, input logic rd, input logic fl);
      core_valid = v;
      read_fifo  = rd;
      flush      = fl;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in('0, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      #3 reset = 1'b0;
      model_clear();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [C-1:0] valid;
      logic         rd;
      logic [C-1:0] exp_ready;
      int           exp_count;
      int           exp_head;
   } vec_t;

   vec_t tbl [16];

   initial begin
      core_index = '0;
      // fairness: all valid 8 cycles, then drain 8
      for (int i = 0; i < 8; i++) begin
         tbl[i]     = '{4'hF, 1'b0, C'(1) << (i % 4), i + 1, 10};
      end
      tbl[8]  = '{4'h0, 1'b1, 4'h0, 7, 11};
      tbl[9]  = '{4'h0, 1'b1, 4'h0, 6, 12};
      tbl[10] = '{4'h0, 1'b1, 4'h0, 5, 13};
      tbl[11] = '{4'h0, 1'b1, 4'h0, 4, 10};
      tbl[12] = '{4'h0, 1'b1, 4'h0, 3, 11};
      tbl[13] = '{4'h0, 1'b1, 4'h0, 2, 12};
      tbl[14] = '{4'h0, 1'b1, 4'h0, 1, 13};
      tbl[15] = '{4'h0, 1'b1, 4'h0, 0, 0};

      do_reset();

      // reset then idle
      check("rst count", count, 0);
      check("rst empty", empty, 1);
      check("rst full", full, 0);
      check("rst head", outlier_pos_fifo, 0);
      check("rst ready", core_ready, 0);
      set_in('0, 1'b1, 1'b0);
      repeat (3) do_cycle("idle_rd");

      // round-robin fairness table
      core_index = {16'd13, 16'd12, 16'd11, 16'd10};
      for (int i = 0; i < 16; i++) begin
         set_in(tbl[i].valid, tbl[i].rd, 1'b0);
         #1;
         check($sformatf("tbl%0d ready", i), core_ready, tbl[i].exp_ready);
         @(posedge clock);
         #1;
         check($sformatf("tbl%0d count", i), count, tbl[i].exp_count);
         check($sformatf("tbl%0d head", i), outlier_pos_fifo, tbl[i].exp_head);
      end
      do_reset();

      // full backpressure with core 2
      core_index = {16'h0000, 16'h0123, 16'h0000, 16'h0000};
      set_in(4'b0100, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) do_cycle("fill");
      check("bp full", full, 1);
      check("bp count", count, DEPTH);
      #1 check("bp ready0", core_ready, 4'b0000);
      set_in(4'b0100, 1'b1, 1'b0);
      do_cycle("bp pop");
      check("bp after pop", count, DEPTH - 1);
      set_in(4'b0100, 1'b0, 1'b0);
      #1 check("bp regrant", core_ready, 4'b0100);
      do_cycle("bp refill");
      check("bp full again", full, 1);
      do_cycle("bp hold");
      check("bp count hold", count, DEPTH);

      // simultaneous write and pop at count 5
      set_in('0, 1'b0, 1'b1);
      do_cycle("flush0");
      core_index = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      set_in(4'b0001, 1'b0, 1'b0);
      repeat (5) do_cycle("push5");
      set_in(4'b1000, 1'b1, 1'b0);
      do_cycle("rw");
      check("rw count5", count, 5);
      check("rw head", outlier_pos_fifo, 16'h1111);

      // flush mid-frame at count 12 leaves rr at 0
      set_in('0, 1'b0, 1'b1);
      do_cycle("flush1");
      set_in(4'b0010, 1'b0, 1'b0);
      repeat (12) do_cycle("push12");
      check("pre-flush count", count, 12);
      set_in(4'hF, 1'b1, 1'b1);
      #1 check("flush ready", core_ready, 0);
      do_cycle("flush");
      check("flush count", count, 0);
      check("flush empty", empty, 1);
      set_in(4'hF, 1'b0, 1'b0);
      #1 check("flush rr0", core_ready, 4'b0001);
      do_cycle("post flush");

      // asynchronous reset mid-cycle at count 30
      set_in(4'hF, 1'b0, 1'b0);
      repeat (29) do_cycle("push30");
      check("pre-rst count", count, 30);
      #2 reset = 1'b1;
      #1;
      check("arst count", count, 0);
      check("arst empty", empty, 1);
      check("arst full", full, 0);
      check("arst head", outlier_pos_fifo, 0);
      check("arst ready", core_ready, 0);
`ifdef OUTLIER_FIFO_STATS_EN
      check("arst total", outlier_total, 0);
`endif
      @(posedge clock);
      #3 reset = 1'b0;
      model_clear();
      set_in('0, 1'b0, 1'b0);
      do_cycle("post arst");

      // randomized run against the model, including pointer wrap and full episodes
      for (int i = 0; i < 1500; i++) begin
         core_index = {$urandom(), $urandom()};
         core_valid = C'($urandom());
         read_fifo  = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 199) == 0);
         do_cycle($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/outlier_fifo_arbiter.md
# outlier_fifo_arbiter

Collects outlier point indices from the `CORE_NUMBER` parallel ROR filter cores and serialises them into one shared FIFO. The testbench or host drains that FIFO after `done`. The block sits between the cores' outlier outputs and the Controller's `outlier_pos_fifo`/`empty`/`read_fifo` port group. It grants one core per cycle in round-robin order and back-pressures the cores when the FIFO is full.

## Interface
- `CORE_NUMBER`, 4, number of requesting cores (1..16).
- `N`, 16, width of one point index.
- `FIFO_DEPTH`, 64, entry count; must be a power of two ≥ 2.
- `AW`, `$clog2(FIFO_DEPTH)`, pointer width (derived; do not override).
- `clock` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `flush` input 1: synchronous clear of the FIFO contents and the round-robin pointer for a new frame.
- `core_valid` input `CORE_NUMBER`: bit c set means core c presents an outlier index.
- `core_index` input `N*CORE_NUMBER`: core c's index in bits `[N*c +: N]`.
- `core_ready` output `CORE_NUMBER`: one-hot grant; a transfer occurs when `core_valid[c] & core_ready[c]`.
- `read_fifo` input 1: pops the head entry on the rising edge.
- `outlier_pos_fifo` output N: head entry, first-word-fall-through; 0 when empty.
- `empty` output 1: FIFO holds no entries.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `count` output `AW+1`: current occupancy.

## Operation
- **Grant (combinational).** When `full=0` and `flush=0`, search `core_valid` starting at `rr_ptr` and wrapping modulo `CORE_NUMBER`.
  - The first set bit receives `core_ready`.
  - At most one bit of `core_ready` is ever high.
  - `core_ready` is all zero when `full=1`, `flush=1`, or no core is valid.
- **Round-robin pointer.** On a transfer from core g, `rr_ptr <= (g+1) mod CORE_NUMBER`. Otherwise `rr_ptr` holds. Core g therefore has the lowest priority on the next cycle.
- **Write.** On a transfer, `mem[wr_ptr] <= core_index[N*g +: N]` and `wr_ptr` increments, wrapping at `FIFO_DEPTH`.
- **Read.** When `read_fifo=1` and `empty=0`, `rd_ptr` increments, wrapping. `read_fifo` while empty is ignored with no underflow and no pointer change.
- **Occupancy.**
  - Write only: `count+1`.
  - Pop only: `count-1`.
  - Write and pop in the same cycle: `count` unchanged.
  - A write is never granted while `full=1`, even if a pop occurs in the same cycle (no full-bypass).
- **Flags.** `empty = (count==0)` and `full = (count==FIFO_DEPTH)`, both decoded from the registered `count`.
- **Flush.** `flush=1` sets `wr_ptr`, `rd_ptr`, `count` and `rr_ptr` to 0 on the edge. A `read_fifo` in the same cycle is discarded.
- **Reset.** Reset produces `count=0`, `empty=1`, `full=0`, `core_ready=0`, `outlier_pos_fifo=0`, and all pointers 0. Memory contents are not reset. Asserting reset mid-frame drops all queued indices.

## Timing
- **Grant latency:** 0 cycles. `core_ready` depends combinationally on `core_valid`, `rr_ptr`, `full` and `flush`.
- **Write-to-visibility latency:** 1 cycle. An index accepted at edge k appears on `outlier_pos_fifo` with `empty=0` after edge k, if the FIFO was empty.
- **Pop:** the next entry, or 0 with `empty=1`, is visible after the popping edge.
- **Throughput:** 1 write and 1 read per cycle.
- **Fairness:** with all cores continuously valid and no backpressure, each core is granted exactly once per `CORE_NUMBER` cycles.
- **Flags:** `full` rises after the edge that writes entry `FIFO_DEPTH`. It falls after the first pop edge.

## Configuration
- **`OUTLIER_FIFO_STATS_EN`** adds output `outlier_total` [31:0].
  - It increments on every accepted transfer and saturates at `32'hFFFF_FFFF`.
  - Clears on reset or `flush`. It is unaffected by pops.
- **Without the macro**, the port and its counter are absent and behaviour is otherwise identical.

## Test plan
- **Reset then idle:** after reset, `empty=1`, `count=0`, `outlier_pos_fifo=0`; `read_fifo=1` for 3 cycles leaves `count=0`.
- **Round-robin fairness:** `CORE_NUMBER=4`, all valid for 8 cycles with indices 10+c, no pops → grants 0,1,2,3,0,1,2,3; FIFO drains as 10,11,12,13,10,11,12,13.
- **Full backpressure:** `FIFO_DEPTH=64`, core 2 valid continuously with index 0x0123, no pops → `full=1` after 64 transfers and `core_ready=0`. A single pop → exactly one more transfer, then `full=1` again.
- **Simultaneous read and write at `count=5`:** one transfer plus one pop → `count` stays 5; data order is preserved across pointer wrap after 70 pushes and 70 pops.
- **Flush mid-frame with `count=12`:** after the flush edge, `count=0`, `empty=1`, `rr_ptr=0`; with `OUTLIER_FIFO_STATS_EN` defined, `outlier_total=0`.
- **Asynchronous reset** asserted mid-cycle with `count=30` → outputs go to reset values immediately, without waiting for a clock edge.
